// File: rtl/ps2_host_tx_if.sv
// Request/response handshake between a core-side requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_strobe;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    modport master (output tx_data, output tx_strobe,
                    input  tx_busy, input  tx_done, input tx_error);
    modport slave  (input  tx_data, input  tx_strobe,
                    output tx_busy, output tx_done, output tx_error);
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 frame transmitter driving open-collector clock/data via output enables.
// Reports device ACK as tx_done, and missing ACK or a stalled device clock as tx_error.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYC = 5000,
    parameter int unsigned TIMEOUT_CYC = 750000,
    parameter int unsigned FILTER      = 8
) (
    input  logic           clk_sys,
    input  logic           reset_n,
    ps2_host_tx_if.slave   tx,
    input  logic           ps2_clk_i,
    input  logic           ps2_data_i,
    output logic           ps2_clk_oe,
    output logic           ps2_data_oe
);
    localparam int unsigned TMAX = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned FW   = (FILTER > 1) ? $clog2(FILTER) : 1;

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE, DONE, ERR
    } state_t;

    state_t          state, state_nxt;
    logic [10:0]     shift, shift_nxt;
    logic [3:0]      bitcnt, bitcnt_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic            data_oe_q, data_oe_nxt;
    logic            clk_oe_q, busy_q, done_q, err_q;

    // Line conditioning: bit 0 = clock, bit 1 = data
    logic [1:0]      sync1, sync2, filt;
    logic [FW-1:0]   fcnt [2];
    logic            clk_filt_d;
    logic            fall_c, timed_c, tmo_c;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= 2'b11;
            sync2      <= 2'b11;
            filt       <= 2'b11;
            clk_filt_d <= 1'b1;
            for (int i = 0; i < 2; i++) fcnt[i] <= '0;
        end else begin
            sync1      <= {ps2_data_i, ps2_clk_i};
            sync2      <= sync1;
            clk_filt_d <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILTER - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FW'(1);
                end
            end
        end
    end

    assign fall_c  = clk_filt_d & ~filt[0];
    assign timed_c = (state == RTS) || (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
    assign tmo_c   = timed_c && (timer == TW'(TIMEOUT_CYC - 1));

    // Next state, shift path and line-drive decisions
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bitcnt_nxt  = bitcnt;
        data_oe_nxt = data_oe_q;
        timer_nxt   = timer;
        unique case (state)
            IDLE, DONE, ERR: begin
                state_nxt = IDLE;
                if (tx.tx_strobe) begin
                    shift_nxt  = {1'b1, ~^tx.tx_data, tx.tx_data};
                    bitcnt_nxt = 4'd0;
                    state_nxt  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (timer == TW'(INHIBIT_CYC - 1)) begin
                    state_nxt   = RTS;
                    data_oe_nxt = 1'b1;
                end
            end
            RTS, SHIFT: begin
                if (fall_c) begin
                    data_oe_nxt = ~shift[0];
                    shift_nxt   = {1'b0, shift[10:1]};
                    bitcnt_nxt  = bitcnt + 4'd1;
                    if (state == RTS)        state_nxt = SHIFT;
                    else if (bitcnt == 4'd9) state_nxt = ACK;
                end else if (tmo_c) begin
                    state_nxt = ERR;
                end
            end
            ACK: begin
                if (fall_c) begin
                    bitcnt_nxt = bitcnt + 4'd1;
                    state_nxt  = filt[1] ? ERR : WAIT_IDLE;
                end else if (tmo_c) begin
                    state_nxt = ERR;
                end
            end
            WAIT_IDLE: begin
                if (filt == 2'b11)  state_nxt = DONE;
                else if (tmo_c)     state_nxt = ERR;
            end
            default: state_nxt = IDLE;
        endcase

        if (!((state_nxt == RTS) || (state_nxt == SHIFT))) data_oe_nxt = 1'b0;

        // Timer restarts on state change and on device edges; saturates instead of wrapping
        if (state_nxt != state)          timer_nxt = '0;
        else if (fall_c && timed_c)      timer_nxt = '0;
        else if (timer != TW'(TMAX))     timer_nxt = timer + TW'(1);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shift     <= '0;
            bitcnt    <= '0;
            timer     <= '0;
            data_oe_q <= 1'b0;
            clk_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift     <= shift_nxt;
            bitcnt    <= bitcnt_nxt;
            timer     <= timer_nxt;
            data_oe_q <= data_oe_nxt;
            clk_oe_q  <= (state_nxt == INHIBIT);
            busy_q    <= !((state_nxt == IDLE) || (state_nxt == DONE) || (state_nxt == ERR));
            done_q    <= (state_nxt == DONE);
            err_q     <= (state_nxt == ERR);
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx.tx_busy  = busy_q;
    assign tx.tx_done  = done_q;
    assign tx.tx_error = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on the open-collector pair, expected wire bits queued at send time.
module tb_ps2_host_tx;
    localparam int unsigned INH  = 20;
    localparam int unsigned TMO  = 400;
    localparam int unsigned FLT  = 4;
    localparam int unsigned HALF = 40;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic reset_n;
    logic ps2_clk_oe, ps2_data_oe;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    wire  ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
    wire  ps2_data_i = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx_if bus();

    ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .FILTER(FLT)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .tx          (bus.slave),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       ack;
        int         exp_done;
        int         exp_err;
    } vec_t;
    vec_t vecs[5];

    always @(negedge clk_sys) begin
        if (bus.tx_done)  done_cnt++;
        if (bus.tx_error) err_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_check(input string name, input logic act);
        logic e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got %0d expected no bit (queue empty)", name, act);
        end else begin
            e = exp_q.pop_front();
            check(name, int'(act), int'(e));
        end
    endtask

    // Strobe a byte and queue the 11 bits the device should see
    task automatic send(input logic [7:0] d, input bit timing);
        @(negedge clk_sys);
        bus.tx_data   = d;
        bus.tx_strobe = 1'b1;
        @(negedge clk_sys);
        bus.tx_strobe = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        exp_q.push_back(($countones(d) % 2 == 0) ? 1'b1 : 1'b0);
        exp_q.push_back(1'b1);
        if (timing) begin
            check("busy_n1", int'(bus.tx_busy), 1);
            check("clk_oe_n1", int'(ps2_clk_oe), 1);
            repeat (INH - 1) @(negedge clk_sys);
            check("clk_oe_last_inh", int'(ps2_clk_oe), 1);
            check("data_oe_inh", int'(ps2_data_oe), 0);
            @(negedge clk_sys);
            check("clk_oe_rts", int'(ps2_clk_oe), 0);
            check("data_oe_rts", int'(ps2_data_oe), 1);
        end
    endtask

    // Device clocks out the frame; stop_at>0 leaves the clock low after that fall
    task automatic dev_frame(input bit ack, input bit inject, input int stop_at);
        int n = 0;
        while (!(ps2_data_oe && !ps2_clk_oe) && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        check("rts_seen", int'(n < 100), 1);
        repeat (HALF) @(negedge clk_sys);
        pop_check("start_bit", ps2_data_i);
        for (int k = 1; k <= 11; k++) begin
            if (inject && k == 5) begin
                bus.tx_data   = 8'h00;
                bus.tx_strobe = 1'b1;
                check("busy_at_2nd_strobe", int'(bus.tx_busy), 1);
                @(negedge clk_sys);
                bus.tx_strobe = 1'b0;
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk_sys);
            if (k == stop_at) return;
            dev_clk_low = 1'b0;
            if (k == 11) begin
                dev_data_low = 1'b0;
            end else begin
                pop_check($sformatf("bit%0d", k), ps2_data_i);
                if (k == 10 && ack) dev_data_low = 1'b1;
            end
            repeat (HALF) @(negedge clk_sys);
        end
    endtask

    task automatic end_frame(input string tag, input int base_d, input int base_e,
                             input int exp_d, input int exp_e);
        int n = 0;
        while (bus.tx_busy && n < 300) begin
            @(negedge clk_sys);
            n++;
        end
        check({tag, "_end_bounded"}, int'(n < 300), 1);
        repeat (2) @(negedge clk_sys);
        check({tag, "_done"}, done_cnt - base_d, exp_d);
        check({tag, "_err"}, err_cnt - base_e, exp_e);
        check({tag, "_oe"}, int'({ps2_clk_oe, ps2_data_oe}), 0);
        check({tag, "_queue_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int bd, be, c;
        vecs[0] = '{data: 8'hED, ack: 1'b1, exp_done: 1, exp_err: 0};
        vecs[1] = '{data: 8'hF4, ack: 1'b1, exp_done: 1, exp_err: 0};
        vecs[2] = '{data: 8'h00, ack: 1'b1, exp_done: 1, exp_err: 0};
        vecs[3] = '{data: 8'hFF, ack: 1'b0, exp_done: 0, exp_err: 1};
        vecs[4] = '{data: 8'h5A, ack: 1'b0, exp_done: 0, exp_err: 1};

        reset_n       = 1'b0;
        bus.tx_strobe = 1'b0;
        bus.tx_data   = 8'h00;
        repeat (3) @(negedge clk_sys);
        check("rst_clk_oe", int'(ps2_clk_oe), 0);
        check("rst_data_oe", int'(ps2_data_oe), 0);
        check("rst_busy", int'(bus.tx_busy), 0);
        check("rst_done", int'(bus.tx_done), 0);
        check("rst_error", int'(bus.tx_error), 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);

        foreach (vecs[i]) begin
            bd = done_cnt;
            be = err_cnt;
            send(vecs[i].data, 1'b1);
            dev_frame(vecs[i].ack, 1'b0, 0);
            end_frame($sformatf("vec%0d", i), bd, be, vecs[i].exp_done, vecs[i].exp_err);
            repeat (10) @(negedge clk_sys);
        end

        // Device never clocks: error exactly TMO cycles after RTS entry
        bd = done_cnt;
        be = err_cnt;
        send(8'hED, 1'b1);
        exp_q.delete();
        c = 0;
        while (!bus.tx_error && c < TMO + 50) begin
            @(negedge clk_sys);
            c++;
        end
        check("timeout_cycles", c, TMO);
        check("timeout_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
        check("timeout_busy", int'(bus.tx_busy), 0);
        repeat (3) @(negedge clk_sys);
        check("timeout_err_cnt", err_cnt - be, 1);
        check("timeout_done_cnt", done_cnt - bd, 0);
        repeat (10) @(negedge clk_sys);

        // Second strobe mid-frame is dropped
        bd = done_cnt;
        be = err_cnt;
        send(8'hF4, 1'b0);
        dev_frame(1'b1, 1'b1, 0);
        end_frame("second_strobe", bd, be, 1, 0);
        repeat (INH + 10) @(negedge clk_sys);
        check("no_second_frame_clk_oe", int'(ps2_clk_oe), 0);
        check("no_second_frame_busy", int'(bus.tx_busy), 0);

        // Reset during bit 4, then a clean frame
        bd = done_cnt;
        be = err_cnt;
        send(8'hED, 1'b0);
        dev_frame(1'b1, 1'b0, 4);
        reset_n = 1'b0;
        #1;
        check("midrst_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
        check("midrst_busy", int'(bus.tx_busy), 0);
        dev_clk_low = 1'b0;
        exp_q.delete();
        repeat (5) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (20) @(negedge clk_sys);
        check("midrst_no_done", done_cnt - bd, 0);
        check("midrst_no_err", err_cnt - be, 0);
        bd = done_cnt;
        be = err_cnt;
        send(8'hED, 1'b1);
        dev_frame(1'b1, 1'b0, 0);
        end_frame("after_rst", bd, be, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It serialises command bytes from the core to a PS/2 keyboard or mouse, such as keyboard LED updates (0xED) or mouse enable (0xF4). It is the send-side counterpart of the PS/2 receivers that decode device-to-host frames. The block sits beside those receivers on the same open-collector ps2_clk/ps2_data pair. It only drives lines low through output-enables and releases them otherwise. It reports completion, ACK failure and timeout to the requester.

## Interface
Parameters:
- INHIBIT_CYC, 5000: clk_sys cycles clock is held low before request-to-send (≥100 µs).
- TIMEOUT_CYC, 750000: maximum clk_sys cycles between consecutive device clock falling edges, and from RTS to the first edge (≥15 ms).
- FILTER, 8: clk_sys cycles a synchronised ps2_clk level must be stable before it is accepted.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tx_data  in  8  byte to send; captured on accepted strobe.
- tx_strobe  in  1  one-cycle request; accepted only when tx_busy=0.
- tx_busy  out  1  high from the cycle after acceptance until done/error pulse.
- tx_done  out  1  one-cycle pulse: frame sent and device ACKed.
- tx_error  out  1  one-cycle pulse: timeout or missing ACK.
- ps2_clk_i  in  1  raw PS/2 clock line level (asynchronous).
- ps2_data_i  in  1  raw PS/2 data line level (asynchronous).
- ps2_clk_oe  out  1  1 = drive clock low.
- ps2_data_oe  out  1  1 = drive data low.

## Operation
- Inputs pass a 2-FF synchroniser. The clock then passes a FILTER-cycle stability filter. A falling edge (fall) is a filtered 1→0 transition.
- Capture: shift register ← {1'b1 stop, ~^tx_data odd parity, tx_data}. bitcnt ← 0.
- States:
  - IDLE: both oe = 0. On tx_strobe, capture data → INHIBIT.
  - INHIBIT: clk_oe = 1 for INHIBIT_CYC cycles. Then → RTS.
  - RTS: data_oe = 1 (start bit). clk_oe = 0. Timer reset. On fall → SHIFT; that edge also outputs bit 0.
  - SHIFT: on each fall, data_oe = ~shift[0], then shift right, bitcnt + 1.
    - Falls 1–8 output D0–D7. Fall 9 outputs parity. Fall 10 outputs stop, releasing data (data_oe = 0).
    - After fall 10 → ACK.
  - ACK: on fall 11, sample filtered data. Low → WAIT_IDLE. High → ERR.
  - WAIT_IDLE: wait for clk and data both high for FILTER cycles → DONE.
  - DONE: tx_done = 1 for one cycle → IDLE.
  - ERR: both oe = 0, tx_error = 1 for one cycle → IDLE.
- Timeout: in RTS, SHIFT, ACK and WAIT_IDLE, a timer counts cycles since the last fall or state entry. When it reaches TIMEOUT_CYC → ERR.
- tx_strobe while busy is ignored; there is no queue.
- Simultaneous timeout and fall in the same cycle: the fall wins and the timer reloads.
- Device activity while IDLE is ignored; the receiver handles it.

## Timing
- Reset values: ps2_clk_oe = 0, ps2_data_oe = 0, tx_busy = 0, tx_done = 0, tx_error = 0. State = IDLE, timer = 0.
- Asserting reset_n low mid-frame releases both lines on the same edge it takes effect, with no done or error pulse.
- Strobe accepted in cycle N:
  - tx_busy = 1 from N+1.
  - ps2_clk_oe = 1 from N+1 through N+INHIBIT_CYC.
  - In cycle N+INHIBIT_CYC+1: ps2_clk_oe = 0 and ps2_data_oe = 1, registered together, with no gap where both are released.
- Data output latency: ps2_data_oe updates 3+FILTER cycles after the raw ps2_clk_i falling edge. This is well inside the device's low phase (≥30 µs).
- tx_done / tx_error and tx_busy deassertion happen in the same cycle.
- Counter widths: the timer is sized by $clog2(TIMEOUT_CYC+1) and never wraps. bitcnt is 4 bits, range 0–11.

## Test plan
- Send 0xED with a device model at a 12.5 kHz clock that ACKs.
  - Data line bits observed at device rising edges: 0, 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Then tx_done pulses once, busy falls, and both oe = 0.
- Send 0xF4: serial bits 0,0,1,0,1,1,1,1, parity 0. With ACK, tx_done = 1 and tx_error stays 0.
- Device model never clocks after RTS: tx_error pulses exactly TIMEOUT_CYC cycles after RTS entry, and lines are released.
- Device leaves data high at fall 11 (no ACK): tx_error pulses and tx_done stays 0.
- Second tx_strobe during SHIFT with tx_data = 0x00: ignored. The frame on the wire remains the first byte, and exactly one tx_done occurs.
- Pull reset_n low during bit 4: both oe drop to 0 immediately, with no pulses. After release, a new 0xED frame completes normally.
